// File: rtl/seq_mult32.sv
// Multi-cycle shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one iteration per clock.
// Optional signed path compiled in with `define SEQ_MULT_SIGNED_EN.
module seq_mult32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is honoured only when the block is idle (busy=0); the
  // result is presented with a single-cycle done pulse, and product then
  // holds until the next done. No backpressure exists on the done side.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplr;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   result;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 neg_in;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 accept;
  logic                 last_iter;

  assign accept    = (state == S_IDLE) && start;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand conditioning: magnitudes in, sign re-applied on the final edge.
`ifdef SEQ_MULT_SIGNED_EN
  always_comb begin
    a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
    neg_in = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
  end
`endif

  always_comb begin
    addend  = mplr[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    acc_nxt = acc + addend;
    result  = neg ? -acc_nxt : acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      mcand <= a_mag;
      mplr  <= b_mag;
      acc   <= '0;
      cnt   <= '0;
      neg   <= neg_in;
    end else if (state == S_RUN) begin
      acc  <= acc_nxt;
      mplr <= mplr >> 1;
      cnt  <= cnt + 1'b1;
      if (last_iter) product <= result;
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: doc/seq_mult32.md
# seq_mult32

Multi-cycle 32×32→64 shift-and-add multiplier for the processor datapath's execute stage. It is the responder side of the ALU issue interface: the datapath issues a multiply with a one-cycle `start` pulse. The block computes the product over WIDTH cycles with no combinational multiplier, then signals completion with a one-cycle `done` pulse. It complements the single-cycle logic units (And32 and the others) for operations too large to finish in one cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand width; product is 2*WIDTH bits; iteration count = WIDTH.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; accepted only in IDLE.
- `a`  in  WIDTH  multiplicand; sampled on the accepting edge.
- `b`  in  WIDTH  multiplier; sampled on the accepting edge.
- `sgn`  in  1  1 = two's-complement operands; sampled with `a`/`b`.
- `busy`  out  1  high from the accepting edge until `done` falls.
- `done`  out  1  one-cycle completion pulse.
- `product`  out  2*WIDTH  result; stable from `done` until the next `done`.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on `start`=1.
  - RUN→DONE after WIDTH iterations.
  - DONE→IDLE unconditionally.
- On accept:
  - Latch `a` into the multiplicand register `mcand` and `b` into the multiplier register `mplr`.
  - Clear the accumulator `acc` (2*WIDTH bits).
  - Clear the iteration counter (log2(WIDTH)+1 bits).
- Each RUN cycle:
  - If `mplr[0]`, add `mcand`, shifted left by the count, into `acc`. An equivalent right-shifting accumulator is acceptable.
  - Shift `mplr` right by one and increment the counter.
- After the final iteration:
  - `product` ← `acc` (see Configuration for the signed case).
  - Enter DONE with `done`=1.
- Unsigned arithmetic is exact modulo 2^(2*WIDTH); no overflow is possible.
- `start` while `busy` (RUN or DONE) is ignored; operands are not re-latched.
- `start` in the cycle `done` is high is ignored. The earliest re-accept is the following cycle (IDLE).
- Operands equal to zero still take the full WIDTH cycles; there is no early termination.

## Timing
- Reset (asynchronous assert, any state):
  - State → IDLE.
  - `busy`=0, `done`=0, `product`=0.
  - Internal registers are cleared.
  - An in-flight operation is discarded with no `done`.
- `start` sampled at edge T:
  - `busy`=1 after T.
  - Iterations at edges T+1 … T+WIDTH.
  - `product` valid and `done`=1 after edge T+WIDTH.
  - `done`=0 and `busy`=0 after edge T+WIDTH+1.
- Latency, accepting edge to `done` rising: WIDTH cycles (32 for the default).
- Maximum throughput: one result per WIDTH+2 cycles.
- `product` changes only on the edge that raises `done`.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined: the signed path is compiled in.
  - With `sgn`=1, operand magnitudes are taken on accept.
  - The result sign is a[WIDTH-1]^b[WIDTH-1].
  - The final `product` is negated (two's complement over 2*WIDTH bits) when the sign is set, on the same edge that raises `done`. Latency is unchanged.
  - The most-negative operand is handled: its magnitude of 2^(WIDTH-1) fits in WIDTH bits unsigned.
- `SEQ_MULT_SIGNED_EN` undefined: `sgn` is ignored and all operations are unsigned. The port remains present.

## Test plan
- `start` with a=3, b=5 at edge T → `done`=1 only in the cycle after T+32, `product`=0x000000000000000F, `busy` high T+1..T+33.
- a=0xFFFFFFFF, b=0xFFFFFFFF, sgn=0 → `product`=0xFFFFFFFE00000001.
- `SEQ_MULT_SIGNED_EN` defined, a=0xFFFFFFFD (−3), b=5, sgn=1 → `product`=0xFFFFFFFFFFFFFFF1.
  - Same macro, a=0x80000000, b=0x80000000, sgn=1 → 0x4000000000000000.
  - Without the macro, a=0xFFFFFFFD, b=5, sgn=1 → 0x00000004FFFFFFF1.
- Second `start` (a=7, b=7) pulsed 10 cycles into a 3×5 run → ignored; `product`=15; exactly one `done`.
  - A `start` pulsed during the `done` cycle is also ignored.
- `rst_n` low 20 cycles into a run → `busy`, `done` and `product` are 0 immediately (asynchronous); no `done` appears. After release, 6×7 → `product`=42.
- Back-to-back: `start` re-asserted the cycle after `done` falls → accepted; second `done` follows 34 cycles after the first.
